// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 byte constants, response codes, decoder states and ps2_key bit positions
package ps2_pkg;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  localparam logic [5:0][7:0] PS2_RESP = {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  localparam int KEY_TOGGLE  = 10;
  localparam int KEY_PRESSED = 9;
  localparam int KEY_EXT     = 8;
  typedef enum logic [2:0] {IDLE, EXT, BRK, EXTBRK, SKIP} dec_state_t;
  function automatic logic is_resp(input logic [7:0] b);
    is_resp = 1'b0;
    for (int i = 0; i < 6; i++) if (b == PS2_RESP[i]) is_resp = 1'b1;
  endfunction
endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronizes and filters the PS/2 lines and receives 11-bit frames.
// Parity is checked only when PS2_PARITY_CHECK_EN is defined.
module ps2_frame_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 25000
) (
  input  logic       clk_25,
  input  logic       RESET_L,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic [7:0] code,
  output logic       byte_vld,
  output logic       frame_err
);
  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [1:0] clk_s, dat_s;
  logic [FW-1:0] fcnt;
  logic filt, filt_d, fall;
  logic [3:0] bitcnt;
  logic [7:0] sr;
  logic [TW-1:0] tcnt;
  logic flip, stop_bit, par_ok, expired;
  assign flip     = clk_s[1] != filt && fcnt == FW'(FILTER_LEN - 1);
  assign stop_bit = fall && bitcnt == 4'd10;
  // a fall in the expiry cycle wins, so expiry requires no fall
  assign expired  = !fall && bitcnt != 4'd0 && tcnt == TW'(TIMEOUT - 1);
  assign code      = sr;
  assign byte_vld  = stop_bit && dat_s[1] && par_ok;
  assign frame_err = (stop_bit && !(dat_s[1] && par_ok)) || expired;
`ifdef PS2_PARITY_CHECK_EN
  logic par;
  always_ff @(posedge clk_25 or negedge RESET_L)
    if (!RESET_L) par <= 1'b0;
    else if (fall && bitcnt == 4'd9) par <= dat_s[1];
  assign par_ok = ^{par, sr};
`else
  assign par_ok = 1'b1;
`endif
  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      clk_s  <= 2'b11;
      dat_s  <= 2'b11;
      fcnt   <= '0;
      filt   <= 1'b1;
      filt_d <= 1'b1;
      fall   <= 1'b0;
      bitcnt <= 4'd0;
      sr     <= 8'd0;
      tcnt   <= '0;
    end else begin
      clk_s  <= {clk_s[0], ps2_clk_in};
      dat_s  <= {dat_s[0], ps2_dat_in};
      fcnt   <= (clk_s[1] == filt || flip) ? '0 : fcnt + 1'b1;
      filt   <= flip ? ~filt : filt;
      filt_d <= filt;
      fall   <= filt_d && !filt;
      tcnt   <= (fall || bitcnt == 4'd0 || expired) ? '0 : tcnt + 1'b1;
      if (expired) bitcnt <= 4'd0;
      else if (fall) bitcnt <= (bitcnt == 4'd0) ? {3'b000, ~dat_s[1]} : (bitcnt == 4'd10) ? 4'd0 : bitcnt + 4'd1;
      if (fall && bitcnt != 4'd0 && bitcnt < 4'd9) sr <= {dat_s[1], sr[7:1]};
    end
  end
endmodule

// File: rtl/ps2_key_gen.sv
// ps2_key_gen: turns raw PS/2 lines into {toggle, pressed, extended, code} key events.
// Optional parity checking via PS2_PARITY_CHECK_EN.
module ps2_key_gen
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 25000
) (
  input  logic        clk_25,
  input  logic        RESET_L,
  input  logic        ps2_clk_in,
  input  logic        ps2_dat_in,
  output logic [10:0] ps2_key,
  output logic        frame_err
);
  logic [7:0] code;
  logic byte_vld;
  dec_state_t state, state_nx;
  logic [2:0] skip, skip_nx;
  logic [10:0] key_nx;
  ps2_frame_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) u_rx (
    .clk_25    (clk_25),
    .RESET_L   (RESET_L),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .code      (code),
    .byte_vld  (byte_vld),
    .frame_err (frame_err)
  );
  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      state   <= IDLE;
      skip    <= 3'd0;
      ps2_key <= 11'h000;
    end else begin
      state   <= state_nx;
      skip    <= skip_nx;
      ps2_key <= key_nx;
    end
  end
  // the Pause sequence bytes are consumed whole, prefixes included
  always_comb begin
    state_nx = state;
    skip_nx  = skip;
    key_nx   = ps2_key;
    if (byte_vld) begin
      if (state == SKIP) begin
        skip_nx  = skip - 3'd1;
        state_nx = (skip == 3'd1) ? IDLE : SKIP;
      end else if (state == IDLE && code == PS2_PAUSE) begin
        state_nx = SKIP;
        skip_nx  = 3'd7;
      end else if (code == PS2_EXT) begin
        state_nx = EXT;
      end else if (code == PS2_BRK) begin
        state_nx = (state == EXT) ? EXTBRK : BRK;
      end else if (!(state == IDLE && is_resp(code))) begin
        key_nx[KEY_TOGGLE]  = ~ps2_key[KEY_TOGGLE];
        key_nx[KEY_PRESSED] = state != BRK && state != EXTBRK;
        key_nx[KEY_EXT]     = state == EXT || state == EXTBRK;
        key_nx[7:0]         = code;
        state_nx            = IDLE;
      end
    end
  end
endmodule

// File: tb/tb_ps2_key_gen.sv
// tb_ps2_key_gen: drives PS/2 frames on the raw lines and checks ps2_key/frame_err against a byte-level model.
module tb_ps2_key_gen;
  logic clk_25 = 1'b0;
  logic RESET_L = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;
  logic [10:0] ps2_key;
  logic frame_err;
  ps2_key_gen dut (
    .clk_25    (clk_25),
    .RESET_L   (RESET_L),
    .ps2_clk_in(ps2_clk),
    .ps2_dat_in(ps2_dat),
    .ps2_key   (ps2_key),
    .frame_err (frame_err)
  );
  always #5 clk_25 = ~clk_25;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  int checks = 0, errors = 0, err_cnt = 0, chg_cnt = 0, prints = 0;
  logic [10:0] exp_key = 11'h000, pend_key = 11'h000;
  bit pend = 0, err_ok = 0;
  logic prev_t = 1'b0;
  bit m_ext = 0, m_brk = 0;
  int m_skip = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // per-cycle tracking of the key word and error pulses
  always @(negedge clk_25) begin
    if (RESET_L) begin
      checks++;
      if (!(ps2_key === exp_key || (pend && ps2_key === pend_key))) begin
        errors++;
        if (prints++ < 10) $display("FAIL key_track: got %0h, expected %0h", ps2_key, pend ? pend_key : exp_key);
      end
      if (frame_err === 1'b1) begin
        err_cnt++;
        if (!err_ok) begin
          errors++;
          $display("FAIL spurious_err: got frame_err 1, expected 0");
        end
      end
      if (ps2_key[10] !== prev_t) chg_cnt++;
      prev_t = ps2_key[10];
    end else prev_t = 1'b0;
  end

  // byte-level reference: prefix flags plus a count of Pause bytes still to swallow
  task automatic model_byte(input logic [7:0] b, input logic [10:0] k, output bit ev, output logic [10:0] nk);
    ev = 0;
    nk = k;
    if (m_skip > 0) m_skip--;
    else if (b == 8'hE1 && !m_ext && !m_brk) m_skip = 7;
    else if (b == 8'hE0) begin m_ext = 1; m_brk = 0; end
    else if (b == 8'hF0) begin m_ext = m_ext && !m_brk; m_brk = 1; end
    else if (!m_ext && !m_brk && (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) ev = 0;
    else begin
      ev = 1;
      nk = {~k[10], ~m_brk, m_ext, b};
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit glitch, input int nbits, input bit lat_ev);
    logic [10:0] fr, k0;
    int n;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = fr[i];
      repeat (12) @(posedge clk_25);
      if (glitch) begin
        #1 ps2_clk = 1'b0;
        repeat (3) @(posedge clk_25);
        #1 ps2_clk = 1'b1;
        repeat (12) @(posedge clk_25);
      end
      @(posedge clk_25);
      #1 k0 = ps2_key;
      ps2_clk = 1'b0;
      if (i == 10 && lat_ev) begin
        n = 0;
        while (n < 40 && ps2_key === k0) begin
          @(posedge clk_25);
          #1 n++;
        end
        check("stop_latency", n, 12);
      end else repeat (15) @(posedge clk_25);
      if (glitch) begin
        #1 ps2_clk = 1'b1;
        repeat (3) @(posedge clk_25);
        #1 ps2_clk = 1'b0;
      end
      repeat (15) @(posedge clk_25);
      #1 ps2_clk = 1'b1;
      repeat (30) @(posedge clk_25);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par = 0, input bit glitch = 0);
    bit ev, drop;
    logic [10:0] nk;
    int e0, c0;
    drop = PAR_EN && bad_par;
    ev = 0;
    nk = exp_key;
    if (!drop) model_byte(b, exp_key, ev, nk);
    pend_key = nk;
    pend = ev;
    err_ok = drop;
    e0 = err_cnt;
    c0 = chg_cnt;
    send_bits(b, bad_par, glitch, 11, ev);
    exp_key = nk;
    pend = 0;
    err_ok = 0;
    check("event_count", chg_cnt - c0, ev);
    check("err_count", err_cnt - e0, drop);
  endtask

  initial begin
    int e0, n;
    logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    repeat (5) @(posedge clk_25);
    #1 check("reset_key", ps2_key, 11'h000);
    check("reset_err", frame_err, 0);
    RESET_L = 1'b1;
    repeat (20) @(posedge clk_25);
    send_byte(8'h75);
    check("pin_make_75", ps2_key, 11'h675);
    send_byte(8'hF0);
    send_byte(8'h75);
    check("pin_break_75", ps2_key, 11'h075);
    send_byte(8'hE0);
    send_byte(8'h74);
    check("pin_ext_74", ps2_key, 11'h774);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h74);
    check("pin_extbrk_74", ps2_key, 11'h174);
    foreach (pause_seq[i]) send_byte(pause_seq[i]);
    check("pin_pause", ps2_key, 11'h174);
    send_byte(8'h29);
    check("pin_after_pause", ps2_key, 11'h629);
    send_byte(8'h1C, 1);
    check("pin_parity", ps2_key, PAR_EN ? 11'h629 : 11'h21C);
    // abandoned frame: clocking stops after D4
    e0 = err_cnt;
    err_ok = 1;
    send_bits(8'h1C, 0, 0, 6, 0);
    n = 0;
    while (err_cnt == e0 && n < 26000) begin
      @(posedge clk_25);
      n++;
    end
    repeat (3) @(posedge clk_25);
    err_ok = 0;
    check("timeout_err", err_cnt - e0, 1);
    check("timeout_key", ps2_key, exp_key);
    send_byte(8'h1C);
    check("pin_after_timeout", ps2_key, PAR_EN ? 11'h21C : 11'h61C);
    send_byte(8'h5A, 0, 1);
    check("pin_glitch", ps2_key, PAR_EN ? 11'h65A : 11'h25A);
    send_byte(8'hAA);
    check("pin_resp_aa", ps2_key, PAR_EN ? 11'h65A : 11'h25A);
    // reset in the middle of a frame
    send_bits(8'h33, 0, 0, 4, 0);
    RESET_L = 1'b0;
    #3 check("midreset_key", ps2_key, 11'h000);
    check("midreset_err", frame_err, 0);
    exp_key = 11'h000;
    m_ext = 0;
    m_brk = 0;
    m_skip = 0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (5) @(posedge clk_25);
    #1 RESET_L = 1'b1;
    repeat (30) @(posedge clk_25);
    send_byte(8'h33);
    check("pin_after_reset", ps2_key, 11'h633);
    for (int i = 0; i < 24; i++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 9);
      b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : (r == 2) ? 8'hE1 : (r == 3) ? 8'hAA : 8'($urandom);
      send_byte(b, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
